uart_fmt_tx: RTL and testbench
==============================

Name: uart_fmt_tx

Overview:
- Parametrised register-dump formatter.
- Turns a (register index, data word) strobe into the ASCII line `<PFX><idx hex>:<data hex>[CR]LF`.
- Generalised in three ways:
  - data width and index width are parameters;
  - optional leading-zero suppression and optional CR;
  - a one-entry pending buffer with drop accounting.
- Feeds a byte-wide valid/ready sink: the tx FIFO in front of the UART core.

Parameters:
- DATA_W, 16: data word width; multiple of 4, range 4..64. NIB = DATA_W/4 hex digits.
- IDX_W, 2: register index width, range 1..8. IDIG = (IDX_W+3)/4 hex digits.
- PFX, 8'h52 ("R"): prefix character.
- SEP, 8'h3A (":"): separator character.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- i_stb, input, 1: request strobe, one cycle per request.
- i_data, input, DATA_W: word to print, sampled with i_stb.
- i_idx, input, IDX_W: register index, sampled with i_stb.
- i_zs, input, 1: suppress leading zero data nibbles, sampled with i_stb.
- i_crlf, input, 1: 1 emits CR then LF; 0 emits LF only. Sampled with i_stb.
- o_byte, output, 8: ASCII byte to sink.
- o_byte_vld, output, 1: o_byte valid.
- i_byte_rdy, input, 1: sink accepts; transfer = o_byte_vld & i_byte_rdy.
- o_busy, output, 1: formatter active or pending entry held.
- o_drop, output, 1: one-cycle pulse when a request is discarded.
- o_drop_cnt, output, 8: saturating count of discarded requests.

Behaviour:
- Reset: all state clears to IDLE and the pending buffer is emptied.
  - o_byte=0, o_byte_vld=0, o_busy=0, o_drop=0, o_drop_cnt=0.
  - Reset mid-message aborts the message with no further bytes.
- States: IDLE, PFX, IDX, SEP, DAT, CR, LF. Active message fields are latched in a working register; an IDX digit counter and a DAT nibble counter are kept.
- Outputs are registered. An i_stb in IDLE at cycle N latches the fields, and o_byte=PFX with o_byte_vld=1 appears at cycle N+1.
- Sink handshake:
  - o_byte and o_byte_vld stay stable until transfer.
  - The state/counter advances only on the transfer cycle.
  - The next byte appears the cycle after transfer, so back-to-back transfers are possible with i_byte_rdy held high.
- Transitions on transfer:
  - PFX -> IDX.
  - IDX: emits IDIG digits MSB first, index zero-extended to 4*IDIG bits, digits 0-9/A-F uppercase; after the last digit -> SEP.
  - SEP -> DAT.
  - DAT: NIB nibbles MSB first. After the last nibble: i_crlf=1 -> CR, else -> LF.
  - CR -> LF.
  - LF -> IDLE, or directly to PFX if the pending buffer is full.
- Zero suppression (i_zs=1):
  - While no non-zero nibble has been emitted and the current nibble is not the last, a zero nibble is skipped.
  - A skip costs one cycle with o_byte_vld=0 and needs no handshake.
  - The last nibble is always emitted, so data 0 prints "0".
- Pending buffer (one entry: data, idx, zs, crlf):
  - i_stb when state!=IDLE and the buffer is empty: the request is captured.
  - i_stb when state!=IDLE and the buffer is full:
    - Normally the request is dropped: o_drop pulses and o_drop_cnt increments, saturating at 255.
    - Exception, LF transfer cycle: the buffer content moves to the working register and the new request is captured into the buffer, with no drop.
  - On the LF transfer cycle with the buffer full, the next cycle presents PFX of the buffered message. No idle gap.
  - i_stb on the LF transfer cycle with the buffer empty: the request is captured to the buffer and starts immediately next cycle.
- o_busy = (state!=IDLE) | pending_valid. Combinational from registers.
- i_stb and reset in the same cycle: reset wins and the request is lost without counting as a drop.

Test Plan:
- DATA_W=16, IDX_W=2; i_idx=2, i_data=16'h0A3F, i_zs=0, i_crlf=1; i_byte_rdy=1.
  -> Bytes "R","2",":","0","A","3","F","\r","\n" on 9 consecutive cycles starting at stb+1; then o_busy=0.
- Same request with i_zs=1 -> "R2:A3F\r\n"; exactly one vld-low cycle between ":" and "A".
- i_data=0, i_zs=1, i_crlf=0 -> "R2:0\n" (3 skip cycles); DATA_W=32, IDX_W=5, idx=5'h13 -> index printed "13".
- Hold i_byte_rdy=0 for 5 cycles during byte "A" -> o_byte stays 8'h41 with vld high; the sequence resumes without loss or duplication.
- Three i_stb on consecutive cycles (idx 0,1,2) -> messages for idx 0 and 1 back-to-back, PFX of the second the cycle after the first LF transfer.
  - idx 2 dropped: o_drop pulses once, o_drop_cnt=1.
  - 256 further drops saturate the count at 255.
- Assert rst during DAT with a pending entry -> next cycle vld=0, busy=0, drop_cnt=0; a fresh stb produces a full correct message.

Source files
------------

// File: rtl/uart_fmt_tx_if.sv
// Request and byte-sink signal bundle for the register-dump formatter.
// master = requester/sink side, slave = formatter side.
interface uart_fmt_tx_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 2
);
  logic              i_stb;
  logic [DATA_W-1:0] i_data;
  logic [IDX_W-1:0]  i_idx;
  logic              i_zs;
  logic              i_crlf;
  logic [7:0]        o_byte;
  logic              o_byte_vld;
  logic              i_byte_rdy;
  logic              o_busy;
  logic              o_drop;
  logic [7:0]        o_drop_cnt;

  modport master (
    output i_stb, i_data, i_idx, i_zs, i_crlf, i_byte_rdy,
    input  o_byte, o_byte_vld, o_busy, o_drop, o_drop_cnt
  );

  modport slave (
    input  i_stb, i_data, i_idx, i_zs, i_crlf, i_byte_rdy,
    output o_byte, o_byte_vld, o_busy, o_drop, o_drop_cnt
  );
endinterface

// File: rtl/uart_fmt_tx.sv
// Formats (index, data) strobes into "<PFX><idx hex><SEP><data hex>[CR]LF"
// on a byte-wide valid/ready sink, with a one-entry pending buffer.
module uart_fmt_tx #(
  parameter int         DATA_W = 16,
  parameter int         IDX_W  = 2,
  parameter logic [7:0] PFX    = 8'h52,
  parameter logic [7:0] SEP    = 8'h3A
) (
  input  logic         clk,
  input  logic         rst,
  uart_fmt_tx_if.slave bus
);
  localparam int         NIB   = DATA_W / 4;
  localparam int         IDIG  = (IDX_W + 3) / 4;
  localparam int         IXW   = 4 * IDIG;
  localparam logic [3:0] DLAST = 4'(NIB - 1);
  localparam logic       ILAST = 1'(IDIG - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PFX, S_IDX, S_SEP, S_DAT, S_CR, S_LF
  } state_t;

  state_t            r_state, w_state_n;
  logic [DATA_W-1:0] r_data, w_data_n;
  logic [IDX_W-1:0]  r_idx, w_idx_n;
  logic              r_zs, w_zs_n;
  logic              r_crlf, w_crlf_n;
  logic              r_p_vld, w_p_vld_n;
  logic [DATA_W-1:0] r_p_data, w_p_data_n;
  logic [IDX_W-1:0]  r_p_idx, w_p_idx_n;
  logic              r_p_zs, w_p_zs_n;
  logic              r_p_crlf, w_p_crlf_n;
  logic              r_icnt, w_icnt_n;
  logic [3:0]        r_dcnt, w_dcnt_n;
  logic              r_nz, w_nz_n;
  logic [7:0]        r_byte, w_byte_n;
  logic              r_vld, w_vld_n;
  logic              r_drop, w_drop_n;
  logic [7:0]        r_drop_cnt, w_drop_cnt_n;
  logic              w_xfer;
  logic              w_lf_xfer;
  logic [IXW-1:0]    w_idx_ext;
  logic [3:0]        w_idig;
  logic [3:0]        w_nib;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign w_xfer    = r_vld & bus.i_byte_rdy;
  assign w_lf_xfer = (r_state == S_LF) & w_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_data     <= '0;
      r_idx      <= '0;
      r_zs       <= 1'b0;
      r_crlf     <= 1'b0;
      r_p_vld    <= 1'b0;
      r_p_data   <= '0;
      r_p_idx    <= '0;
      r_p_zs     <= 1'b0;
      r_p_crlf   <= 1'b0;
      r_icnt     <= 1'b0;
      r_dcnt     <= '0;
      r_nz       <= 1'b0;
      r_byte     <= '0;
      r_vld      <= 1'b0;
      r_drop     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_n;
      r_data     <= w_data_n;
      r_idx      <= w_idx_n;
      r_zs       <= w_zs_n;
      r_crlf     <= w_crlf_n;
      r_p_vld    <= w_p_vld_n;
      r_p_data   <= w_p_data_n;
      r_p_idx    <= w_p_idx_n;
      r_p_zs     <= w_p_zs_n;
      r_p_crlf   <= w_p_crlf_n;
      r_icnt     <= w_icnt_n;
      r_dcnt     <= w_dcnt_n;
      r_nz       <= w_nz_n;
      r_byte     <= w_byte_n;
      r_vld      <= w_vld_n;
      r_drop     <= w_drop_n;
      r_drop_cnt <= w_drop_cnt_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_data_n     = r_data;
    w_idx_n      = r_idx;
    w_zs_n       = r_zs;
    w_crlf_n     = r_crlf;
    w_p_vld_n    = r_p_vld;
    w_p_data_n   = r_p_data;
    w_p_idx_n    = r_p_idx;
    w_p_zs_n     = r_p_zs;
    w_p_crlf_n   = r_p_crlf;
    w_icnt_n     = r_icnt;
    w_dcnt_n     = r_dcnt;
    w_nz_n       = r_nz;
    w_drop_n     = 1'b0;
    w_drop_cnt_n = r_drop_cnt;
    w_byte_n     = '0;
    w_vld_n      = 1'b0;

    case (r_state)
      S_IDLE: if (bus.i_stb) begin
        w_data_n  = bus.i_data;
        w_idx_n   = bus.i_idx;
        w_zs_n    = bus.i_zs;
        w_crlf_n  = bus.i_crlf;
        w_state_n = S_PFX;
      end
      S_PFX: if (w_xfer) begin
        w_state_n = S_IDX;
        w_icnt_n  = 1'b0;
      end
      S_IDX: if (w_xfer) begin
        if (r_icnt == ILAST) w_state_n = S_SEP;
        else                 w_icnt_n  = r_icnt + 1'b1;
      end
      S_SEP: if (w_xfer) begin
        w_state_n = S_DAT;
        w_dcnt_n  = '0;
        w_nz_n    = 1'b0;
      end
      // vld low in DAT marks a suppressed nibble, which advances unconditionally
      S_DAT: if (!r_vld || w_xfer) begin
        if (r_vld) w_nz_n = 1'b1;
        if (r_dcnt == DLAST) w_state_n = r_crlf ? S_CR : S_LF;
        else                 w_dcnt_n  = r_dcnt + 4'd1;
      end
      S_CR: if (w_xfer) w_state_n = S_LF;
      S_LF: if (w_xfer) begin
        if (r_p_vld) begin
          w_data_n   = r_p_data;
          w_idx_n    = r_p_idx;
          w_zs_n     = r_p_zs;
          w_crlf_n   = r_p_crlf;
          w_state_n  = S_PFX;
          w_p_vld_n  = bus.i_stb;
          w_p_data_n = bus.i_data;
          w_p_idx_n  = bus.i_idx;
          w_p_zs_n   = bus.i_zs;
          w_p_crlf_n = bus.i_crlf;
        end else if (bus.i_stb) begin
          // buffer empty: the request goes straight to the working register
          w_data_n  = bus.i_data;
          w_idx_n   = bus.i_idx;
          w_zs_n    = bus.i_zs;
          w_crlf_n  = bus.i_crlf;
          w_state_n = S_PFX;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (bus.i_stb && (r_state != S_IDLE) && !w_lf_xfer) begin
      if (!r_p_vld) begin
        w_p_vld_n  = 1'b1;
        w_p_data_n = bus.i_data;
        w_p_idx_n  = bus.i_idx;
        w_p_zs_n   = bus.i_zs;
        w_p_crlf_n = bus.i_crlf;
      end else begin
        w_drop_n = 1'b1;
        if (r_drop_cnt != 8'hFF) w_drop_cnt_n = r_drop_cnt + 8'd1;
      end
    end

    // registered outputs are derived from the next-cycle state and counters
    w_idx_ext = IXW'(w_idx_n);
    w_idig    = 4'(w_idx_ext >> {ILAST - w_icnt_n, 2'b00});
    w_nib     = 4'(w_data_n >> {DLAST - w_dcnt_n, 2'b00});

    case (w_state_n)
      S_PFX: begin w_byte_n = PFX;              w_vld_n = 1'b1; end
      S_IDX: begin w_byte_n = hex_char(w_idig); w_vld_n = 1'b1; end
      S_SEP: begin w_byte_n = SEP;              w_vld_n = 1'b1; end
      S_DAT: begin
        w_byte_n = hex_char(w_nib);
        w_vld_n  = !(w_zs_n && !w_nz_n && (w_nib == 4'd0) && (w_dcnt_n != DLAST));
      end
      S_CR:  begin w_byte_n = 8'h0D; w_vld_n = 1'b1; end
      S_LF:  begin w_byte_n = 8'h0A; w_vld_n = 1'b1; end
      default: begin w_byte_n = '0; w_vld_n = 1'b0; end
    endcase
  end

  assign bus.o_byte     = r_byte;
  assign bus.o_byte_vld = r_vld;
  assign bus.o_busy     = (r_state != S_IDLE) | r_p_vld;
  assign bus.o_drop     = r_drop;
  assign bus.o_drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_uart_fmt_tx.sv
// Bench for uart_fmt_tx: directed steps plus randomized messages against a
// string-building reference model, on a 16/2 and a 32/5 instance.
module tb_uart_fmt_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   drop_seen = 0;

  logic [7:0] capA[$];
  int         capA_c[$];
  logic [7:0] capB[$];
  int         capB_c[$];
  logic [7:0] expA[$];
  logic [7:0] expB[$];
  int         rdA = 0;
  int         rdB = 0;

  uart_fmt_tx_if #(.DATA_W(16), .IDX_W(2)) ifa ();
  uart_fmt_tx_if #(.DATA_W(32), .IDX_W(5)) ifb ();

  uart_fmt_tx #(.DATA_W(16), .IDX_W(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  uart_fmt_tx #(.DATA_W(32), .IDX_W(5)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && ifa.o_byte_vld && ifa.i_byte_rdy) begin
      capA.push_back(ifa.o_byte);
      capA_c.push_back(cyc);
    end
    if (!rst && ifb.o_byte_vld && ifb.i_byte_rdy) begin
      capB.push_back(ifb.o_byte);
      capB_c.push_back(cyc);
    end
    if (!rst && ifa.o_drop) drop_seen <= drop_seen + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  function automatic void push(input bit b, input logic [7:0] v);
    if (b) expB.push_back(v);
    else   expA.push_back(v);
  endfunction

  // Expected text of one message, built digit by digit from the field values.
  function automatic void model(input bit b, input int dw, input int iw, input logic [63:0] d,
                                input logic [7:0] ix, input bit zs, input bit crlf);
    int nib = dw / 4;
    int idig = (iw + 3) / 4;
    bit started = 1'b0;
    int n;
    push(b, 8'h52);
    for (int i = idig - 1; i >= 0; i--) push(b, hexc(int'((ix >> (4 * i)) & 8'hF)));
    push(b, 8'h3A);
    for (int i = nib - 1; i >= 0; i--) begin
      n = int'((d >> (4 * i)) & 64'hF);
      if (!(zs && !started && n == 0 && i != 0)) begin
        started = 1'b1;
        push(b, hexc(n));
      end
    end
    if (crlf) push(b, 8'h0D);
    push(b, 8'h0A);
  endfunction

  function automatic logic [63:0] rnd_word(input int nib);
    logic [63:0] w = '0;
    for (int i = 0; i < nib; i++)
      w = (w << 4) | ($urandom_range(1) ? 64'd0 : 64'($urandom_range(15)));
    return w;
  endfunction

  task automatic check_stream(input bit b, input string tag);
    int nc;
    if (!b) begin
      nc = capA.size() - rdA;
      chk({tag, "_len"}, nc, expA.size());
      for (int i = 0; i < nc && i < expA.size(); i++) chk(tag, capA[rdA + i], expA[i]);
      rdA = capA.size();
      expA.delete();
    end else begin
      nc = capB.size() - rdB;
      chk({tag, "_len"}, nc, expB.size());
      for (int i = 0; i < nc && i < expB.size(); i++) chk(tag, capB[rdB + i], expB[i]);
      rdB = capB.size();
      expB.delete();
    end
  endtask

  task automatic wait_idle(input bit b, input int budget, input int rdy_pct, input string tag);
    int k = 0;
    while ((b ? ifb.o_busy : ifa.o_busy) && k < budget) begin
      if (b) ifb.i_byte_rdy = ($urandom_range(99) < rdy_pct);
      else   ifa.i_byte_rdy = ($urandom_range(99) < rdy_pct);
      step();
      k++;
    end
    ifa.i_byte_rdy = 1'b1;
    ifb.i_byte_rdy = 1'b1;
    chk({tag, "_idle"}, b ? ifb.o_busy : ifa.o_busy, 1'b0);
  endtask

  task automatic send_a(input logic [15:0] d, input logic [1:0] ix, input bit zs, input bit crlf);
    ifa.i_stb = 1'b1; ifa.i_data = d; ifa.i_idx = ix; ifa.i_zs = zs; ifa.i_crlf = crlf;
    step();
    ifa.i_stb = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic [4:0] ix, input bit zs, input bit crlf);
    ifb.i_stb = 1'b1; ifb.i_data = d; ifb.i_idx = ix; ifb.i_zs = zs; ifb.i_crlf = crlf;
    step();
    ifb.i_stb = 1'b0;
  endtask

  initial begin
    int c0, d0, k;
    logic [15:0] da, db;
    logic [31:0] dw;
    ifa.i_stb = 0; ifa.i_data = '0; ifa.i_idx = '0; ifa.i_zs = 0; ifa.i_crlf = 0; ifa.i_byte_rdy = 1;
    ifb.i_stb = 0; ifb.i_data = '0; ifb.i_idx = '0; ifb.i_zs = 0; ifb.i_crlf = 0; ifb.i_byte_rdy = 1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_byte", ifa.o_byte, 8'h00);
    chk("rst_vld", ifa.o_byte_vld, 1'b0);
    chk("rst_busy", ifa.o_busy, 1'b0);
    chk("rst_drop", ifa.o_drop, 1'b0);
    chk("rst_dcnt", ifa.o_drop_cnt, 8'h00);

    // basic message, exact cycle placement
    c0 = cyc;
    send_a(16'h0A3F, 2'd2, 1'b0, 1'b1);
    model(0, 16, 2, 64'h0A3F, 8'd2, 1'b0, 1'b1);
    wait_idle(0, 40, 100, "basic");
    for (int j = 0; j < 9 && rdA + j < capA_c.size(); j++) chk("basic_cyc", capA_c[rdA + j], c0 + 1 + j);
    check_stream(0, "basic");

    // zero suppression: one skip cycle
    send_a(16'h0A3F, 2'd2, 1'b1, 1'b1);
    model(0, 16, 2, 64'h0A3F, 8'd2, 1'b1, 1'b1);
    wait_idle(0, 40, 100, "zs");
    if (capA_c.size() >= rdA + 4) chk("zs_gap", capA_c[rdA + 3] - capA_c[rdA + 2], 2);
    check_stream(0, "zs");

    // all-zero data, LF only: three skips
    send_a(16'h0000, 2'd2, 1'b1, 1'b0);
    model(0, 16, 2, 64'h0, 8'd2, 1'b1, 1'b0);
    wait_idle(0, 40, 100, "zero");
    if (capA_c.size() >= rdA + 4) chk("zero_gap", capA_c[rdA + 3] - capA_c[rdA + 2], 4);
    check_stream(0, "zero");

    // wide instance, two-digit index
    dw = 32'(rnd_word(8));
    send_b(dw, 5'h13, 1'b0, 1'b1);
    model(1, 32, 5, 64'(dw), 8'h13, 1'b0, 1'b1);
    wait_idle(1, 60, 100, "wide");
    if (capB.size() >= rdB + 3) begin
      chk("wide_idx_hi", capB[rdB + 1], 8'h31);
      chk("wide_idx_lo", capB[rdB + 2], 8'h33);
    end
    check_stream(1, "wide");

    // backpressure on byte "A"
    send_a(16'h0A3F, 2'd1, 1'b0, 1'b1);
    model(0, 16, 2, 64'h0A3F, 8'd1, 1'b0, 1'b1);
    k = 0;
    while (!(ifa.o_byte_vld && ifa.o_byte == 8'h41) && k < 20) begin step(); k++; end
    chk("bp_found", k < 20, 1'b1);
    ifa.i_byte_rdy = 1'b0;
    repeat (5) begin
      chk("bp_byte", ifa.o_byte, 8'h41);
      chk("bp_vld", ifa.o_byte_vld, 1'b1);
      step();
    end
    ifa.i_byte_rdy = 1'b1;
    wait_idle(0, 40, 100, "bp");
    check_stream(0, "bp");

    // three strobes back to back: two messages, one drop
    d0 = drop_seen;
    da = 16'(rnd_word(4));
    db = 16'(rnd_word(4));
    c0 = cyc;
    ifa.i_stb = 1'b1; ifa.i_zs = 1'b0; ifa.i_crlf = 1'b1;
    ifa.i_idx = 2'd0; ifa.i_data = da; step();
    ifa.i_idx = 2'd1; ifa.i_data = db; step();
    ifa.i_idx = 2'd2; ifa.i_data = 16'hFFFF; step();
    ifa.i_stb = 1'b0;
    model(0, 16, 2, 64'(da), 8'd0, 1'b0, 1'b1);
    model(0, 16, 2, 64'(db), 8'd1, 1'b0, 1'b1);
    wait_idle(0, 60, 100, "b2b");
    if (capA_c.size() >= rdA + 10) begin
      chk("b2b_first", capA_c[rdA], c0 + 1);
      chk("b2b_gap", capA_c[rdA + 9] - capA_c[rdA + 8], 1);
    end
    check_stream(0, "b2b");
    chk("b2b_drops", drop_seen - d0, 1);
    chk("b2b_dcnt", ifa.o_drop_cnt, 8'd1);

    // 256 further drops saturate the counter
    d0 = drop_seen;
    ifa.i_byte_rdy = 1'b0;
    ifa.i_stb = 1'b1; ifa.i_idx = 2'd3; ifa.i_data = da; ifa.i_zs = 1'b1; ifa.i_crlf = 1'b0;
    repeat (258) step();
    ifa.i_stb = 1'b0;
    step(); step();
    chk("sat_drops", drop_seen - d0, 256);
    chk("sat_dcnt", ifa.o_drop_cnt, 8'hFF);
    model(0, 16, 2, 64'(da), 8'd3, 1'b1, 1'b0);
    model(0, 16, 2, 64'(da), 8'd3, 1'b1, 1'b0);
    wait_idle(0, 80, 100, "sat");
    check_stream(0, "sat");

    // reset mid-message with a pending entry
    send_a(16'hBEEF, 2'd1, 1'b0, 1'b1);
    send_a(16'h1234, 2'd2, 1'b0, 1'b1);
    k = 0;
    while (capA.size() - rdA < 4 && k < 30) begin step(); k++; end
    chk("abort_reach", k < 30, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_vld", ifa.o_byte_vld, 1'b0);
    chk("abort_busy", ifa.o_busy, 1'b0);
    chk("abort_dcnt", ifa.o_drop_cnt, 8'd0);
    rdA = capA.size();
    repeat (5) step();
    chk("abort_quiet", capA.size() - rdA, 0);

    // strobe coincident with reset is lost without a drop
    rst = 1'b1; ifa.i_stb = 1'b1; ifa.i_data = 16'h5555;
    step();
    rst = 1'b0; ifa.i_stb = 1'b0;
    repeat (3) step();
    chk("rststb_busy", ifa.o_busy, 1'b0);
    chk("rststb_dcnt", ifa.o_drop_cnt, 8'd0);
    chk("rststb_quiet", capA.size() - rdA, 0);

    send_a(16'hC0DE, 2'd3, 1'b1, 1'b1);
    model(0, 16, 2, 64'hC0DE, 8'd3, 1'b1, 1'b1);
    wait_idle(0, 40, 100, "fresh");
    check_stream(0, "fresh");

    // randomized traffic with random backpressure
    for (int m = 0; m < 40; m++) begin
      bit zs, cr;
      da = 16'(rnd_word(4)); zs = 1'($urandom_range(1)); cr = 1'($urandom_range(1));
      k = $urandom_range(3);
      send_a(da, 2'(k), zs, cr);
      model(0, 16, 2, 64'(da), 8'(k), zs, cr);
      if ($urandom_range(1) == 1) begin
        db = 16'(rnd_word(4));
        send_a(db, 2'(k ^ 1), cr, zs);
        model(0, 16, 2, 64'(db), 8'(k ^ 1), cr, zs);
      end
      wait_idle(0, 300, 70, "rand_a");
    end
    check_stream(0, "rand_a");

    for (int m = 0; m < 10; m++) begin
      bit zs, cr;
      dw = 32'(rnd_word(8)); zs = 1'($urandom_range(1)); cr = 1'($urandom_range(1));
      k = $urandom_range(31);
      send_b(dw, 5'(k), zs, cr);
      model(1, 32, 5, 64'(dw), 8'(k), zs, cr);
      wait_idle(1, 300, 70, "rand_b");
    end
    check_stream(1, "rand_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
